// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and the March C- element table for the MBIST sequencer.
//   state_t    - sequencer FSM states (IDLE -> RUN -> DRAIN -> DONE)
//   op_t       - memory operation encoding {RD, WR}
//   elem_t     - per-element descriptor: op count, first op, first-op data, direction
//   NUM_ELEM   - number of march elements (6)
//   elem_info  - element table lookup
//   elem_down  - address direction of an element
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    typedef struct packed {
        logic two_ops;    // read followed by write at each address
        op_t  first_op;
        logic first_one;  // first op uses the inverted background
        logic down;       // descending address order
    } elem_t;

    localparam logic [2:0] NUM_ELEM = 3'd6;

    // {w0} {r0,w1} {r1,w0} {r0,w1}down {r1,w0}down {r0}; second op always writes the inverse
    function automatic elem_t elem_info(input logic [2:0] elem);
        elem_t e;
        case (elem)
            3'd0:    e = '{two_ops: 1'b0, first_op: OP_WR, first_one: 1'b0, down: 1'b0};
            3'd1:    e = '{two_ops: 1'b1, first_op: OP_RD, first_one: 1'b0, down: 1'b0};
            3'd2:    e = '{two_ops: 1'b1, first_op: OP_RD, first_one: 1'b1, down: 1'b0};
            3'd3:    e = '{two_ops: 1'b1, first_op: OP_RD, first_one: 1'b0, down: 1'b1};
            3'd4:    e = '{two_ops: 1'b1, first_op: OP_RD, first_one: 1'b1, down: 1'b1};
            3'd5:    e = '{two_ops: 1'b0, first_op: OP_RD, first_one: 1'b0, down: 1'b0};
            default: e = '{two_ops: 1'b0, first_op: OP_RD, first_one: 1'b0, down: 1'b0};
        endcase
        return e;
    endfunction

    function automatic logic elem_down(input logic [2:0] elem);
        elem_t e;
        e = elem_info(elem);
        return e.down;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter for the march sequencer.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - load start address (all-ones when load_down, else zero)
//   load_down  - direction of the element being loaded
//   step       - advance one address in direction 'down'
//   down       - direction of the element currently running
//   addr       - current address
//   last       - addr is the final address for direction 'down'
module mbist_addr_gen #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    assign last = down ? (addr == '0) : (addr == '1);

    // address counter: load has priority over step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
        end else begin
            addr <= addr;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- MBIST sequencer for one single-port SRAM.
//   MCK, RSTN      - clock, asynchronous active-low reset
//   men            - run enable (level); dropping it returns to IDLE
//   mgo            - pass flag (sticky 0 on any mismatch until next start)
//   mrd            - test complete
//   mem_cen/wen/oen- SRAM strobes, active-low
//   mem_a, mem_d   - SRAM address / write data (held while idle)
//   mem_q          - SRAM read data, valid one cycle after the read access
//   fail_addr/elem - first failing address / march element
// Optional feature: define MBIST_DIAG_EN to capture the first failing address/element;
// otherwise fail_addr and fail_elem are tied to zero.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BG_PATTERN = '0
) (
    input  logic              MCK,
    input  logic              RSTN,
    input  logic              men,
    output logic              mgo,
    output logic              mrd,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_t            state_r;
    logic [2:0]        elem_r;
    logic              op_r;
    logic              rd_p1_r;
    logic              cmp_v_r;
    logic [DATA_W-1:0] exp_p1_r;
    logic [DATA_W-1:0] exp_p2_r;

    elem_t             info_s;
    op_t               cur_op_s;
    logic              data_one_s;
    logic [DATA_W-1:0] word_s;
    logic              last_op_s;
    logic              start_s;
    logic              issue_s;
    logic              mismatch_s;
    logic              ag_load_s;
    logic              ag_load_down_s;
    logic              ag_step_s;
    logic              ag_last_s;
    logic [ADDR_W-1:0] ag_addr_s;

    assign info_s         = elem_info(elem_r);
    assign cur_op_s       = op_r ? OP_WR : info_s.first_op;
    assign data_one_s     = op_r ? ~info_s.first_one : info_s.first_one;
    assign word_s         = data_one_s ? ~BG_PATTERN : BG_PATTERN;
    assign last_op_s      = ~info_s.two_ops | op_r;
    assign start_s        = (state_r == ST_IDLE) & men;
    // elem_r == NUM_ELEM marks "all ops issued": RUN then leaves for DRAIN
    assign issue_s        = (state_r == ST_RUN) & men & (elem_r < NUM_ELEM);
    assign mismatch_s     = cmp_v_r & (mem_q != exp_p2_r);
    assign ag_load_s      = start_s | (issue_s & last_op_s & ag_last_s);
    assign ag_load_down_s = start_s ? elem_down(3'd0) : elem_down(elem_r + 3'd1);
    assign ag_step_s      = issue_s & last_op_s & ~ag_last_s;

    mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (MCK),
        .rst_n     (RSTN),
        .load      (ag_load_s),
        .load_down (ag_load_down_s),
        .step      (ag_step_s),
        .down      (info_s.down),
        .addr      (ag_addr_s),
        .last      (ag_last_s)
    );

    // sequencer FSM, registered memory strobes and read-compare pipeline
    always_ff @(posedge MCK or negedge RSTN) begin
        if (!RSTN) begin
            state_r  <= ST_IDLE;
            elem_r   <= 3'd0;
            op_r     <= 1'b0;
            rd_p1_r  <= 1'b0;
            cmp_v_r  <= 1'b0;
            exp_p1_r <= '0;
            exp_p2_r <= '0;
            mgo      <= 1'b0;
            mrd      <= 1'b0;
            mem_cen  <= 1'b1;
            mem_wen  <= 1'b1;
            mem_oen  <= 1'b1;
            mem_a    <= '0;
            mem_d    <= '0;
        end else if (!men) begin
            // abort: any compare due on this edge is discarded, mgo keeps its value
            state_r <= ST_IDLE;
            rd_p1_r <= 1'b0;
            cmp_v_r <= 1'b0;
            mrd     <= 1'b0;
            mem_cen <= 1'b1;
            mem_wen <= 1'b1;
            mem_oen <= 1'b1;
        end else begin
            // stage 1 marks the access cycle, stage 2 the cycle mem_q is valid
            cmp_v_r  <= rd_p1_r;
            exp_p2_r <= exp_p1_r;
            if (mismatch_s) begin
                mgo <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_RUN;
                    elem_r  <= 3'd0;
                    op_r    <= 1'b0;
                    rd_p1_r <= 1'b0;
                    cmp_v_r <= 1'b0;
                    mgo     <= 1'b1;
                    mrd     <= 1'b0;
                end
                ST_RUN: begin
                    if (issue_s) begin
                        mem_cen  <= 1'b0;
                        mem_oen  <= 1'b0;
                        mem_wen  <= (cur_op_s == OP_WR) ? 1'b0 : 1'b1;
                        mem_a    <= ag_addr_s;
                        if (cur_op_s == OP_WR) begin
                            mem_d <= word_s;
                        end
                        rd_p1_r  <= (cur_op_s == OP_RD);
                        exp_p1_r <= word_s;
                        if (last_op_s) begin
                            op_r <= 1'b0;
                            if (ag_last_s) begin
                                elem_r <= elem_r + 3'd1;
                            end
                        end else begin
                            op_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_DRAIN;
                        rd_p1_r <= 1'b0;
                        mem_cen <= 1'b1;
                        mem_wen <= 1'b1;
                        mem_oen <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_DONE;
                    mrd     <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                    mrd     <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_p1_r <= 1'b0;
                    mem_cen <= 1'b1;
                    mem_wen <= 1'b1;
                    mem_oen <= 1'b1;
                end
            endcase
        end
    end

`ifdef MBIST_DIAG_EN
    logic [ADDR_W-1:0] addr_p1_r;
    logic [ADDR_W-1:0] addr_p2_r;
    logic [2:0]        elem_p1_r;
    logic [2:0]        elem_p2_r;
    logic              fail_seen_r;

    // address/element pipeline aligned with the compare, first-failure capture
    always_ff @(posedge MCK or negedge RSTN) begin
        if (!RSTN) begin
            addr_p1_r   <= '0;
            addr_p2_r   <= '0;
            elem_p1_r   <= 3'd0;
            elem_p2_r   <= 3'd0;
            fail_seen_r <= 1'b0;
            fail_addr   <= '0;
            fail_elem   <= 3'd0;
        end else begin
            if (issue_s) begin
                addr_p1_r <= ag_addr_s;
                elem_p1_r <= elem_r;
            end
            addr_p2_r <= addr_p1_r;
            elem_p2_r <= elem_p1_r;
            if (start_s) begin
                fail_seen_r <= 1'b0;
                fail_addr   <= '0;
                fail_elem   <= 3'd0;
            end else if (mismatch_s && men && !fail_seen_r) begin
                fail_seen_r <= 1'b1;
                fail_addr   <= addr_p2_r;
                fail_elem   <= elem_p2_r;
            end
        end
    end
`else
    assign fail_addr = '0;
    assign fail_elem = 3'd0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
`timescale 1ns/1ps
module tb_mbist_march_ctrl;

    localparam int AW     = 4;
    localparam int DW     = 32;
    localparam int DEPTH  = 1 << AW;
    localparam int NOPS   = 10 * DEPTH;
    localparam int BAW    = 12;
    localparam int BDW    = 8;
    localparam int BUDGET = 1000;

    logic MCK = 1'b0;
    always #5 MCK = ~MCK;

    logic          RSTN;
    logic          men;
    logic          mgo, mrd, mem_cen, mem_wen, mem_oen;
    logic [AW-1:0] mem_a, fail_addr;
    logic [DW-1:0] mem_d, mem_q;
    logic [2:0]    fail_elem;

    logic           men_b;
    logic           mgo_b, mrd_b, cen_b, wen_b, oen_b;
    logic [BAW-1:0] a_b, fa_b;
    logic [BDW-1:0] d_b, q_b;
    logic [2:0]     fe_b;

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .MCK(MCK), .RSTN(RSTN), .men(men), .mgo(mgo), .mrd(mrd),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
        .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
        .fail_addr(fail_addr), .fail_elem(fail_elem)
    );

    mbist_march_ctrl #(.ADDR_W(BAW), .DATA_W(BDW)) u_dut_big (
        .MCK(MCK), .RSTN(RSTN), .men(men_b), .mgo(mgo_b), .mrd(mrd_b),
        .mem_cen(cen_b), .mem_wen(wen_b), .mem_oen(oen_b),
        .mem_a(a_b), .mem_d(d_b), .mem_q(q_b),
        .fail_addr(fa_b), .fail_elem(fe_b)
    );

    // behavioural SRAMs; the small one can inject a stuck-at fault on one bit of one address
    logic [DW-1:0]  sram   [DEPTH];
    logic [BDW-1:0] sram_b [1 << BAW];
    int fault_mode = 0;
    int fault_addr = 0;
    int fault_bit  = 0;

    function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] w, input int a);
        logic [DW-1:0] m;
        m = '0;
        m[fault_bit] = 1'b1;
        if (a == fault_addr && fault_mode == 1) return w | m;
        else if (a == fault_addr && fault_mode == 2) return w & ~m;
        else return w;
    endfunction

    always @(posedge MCK) begin
        if (mem_cen == 1'b0) begin
            if (mem_wen == 1'b0) sram[mem_a] <= mem_d;
            else mem_q <= apply_fault(sram[mem_a], int'(mem_a));
        end
        if (cen_b == 1'b0) begin
            if (wen_b == 1'b0) sram_b[a_b] <= d_b;
            else q_b <= sram_b[a_b];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard of expected memory operations, filled from an independent March C- table
    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_rec_t;
    op_rec_t sb_q[$];

    task automatic push_march();
        int      nops [6];
        bit      fwr  [6];
        bit      fone [6];
        int      a;
        op_rec_t r;
        nops = '{1, 2, 2, 2, 2, 1};
        fwr  = '{1, 0, 0, 0, 0, 0};
        fone = '{0, 0, 1, 0, 1, 0};
        sb_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a    = (e == 3 || e == 4) ? (DEPTH - 1 - i) : i;
                r.wr = fwr[e];
                r.a  = a[AW-1:0];
                r.d  = fone[e] ? {DW{1'b1}} : {DW{1'b0}};
                sb_q.push_back(r);
                if (nops[e] == 2) begin
                    r.wr = 1'b1;
                    r.d  = ~r.d;
                    sb_q.push_back(r);
                end
            end
        end
    endtask

    // every active memory cycle must match the next expected op
    always @(negedge MCK) begin
        op_rec_t r;
        if (RSTN === 1'b1 && mem_cen === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL extra_op actual a=%0d wen=%0b required no access", mem_a, mem_wen);
            end else begin
                r = sb_q.pop_front();
                if (mem_wen !== ~r.wr || mem_a !== r.a || mem_oen !== 1'b0 ||
                    (r.wr && mem_d !== r.d)) begin
                    errors++;
                    $display("FAIL mem_op actual wen=%0b oen=%0b a=%0d d=%0h required wen=%0b oen=0 a=%0d d=%0h",
                             mem_wen, mem_oen, mem_a, mem_d, ~r.wr, r.a, r.d);
                end
            end
        end
    end

    typedef struct {
        int   fmode;
        int   faddr;
        int   fbit;
        logic exp_mgo_mid;   // mgo at cycle 60 (inside element 2)
        logic exp_mgo;
        int   exp_faddr;
        int   exp_felem;
    } vec_t;
    vec_t vecs [4];

    task automatic run_vec(input vec_t v);
        int n;
        int bad;
        int efa;
        int efe;
        fault_mode = v.fmode;
        fault_addr = v.faddr;
        fault_bit  = v.fbit;
`ifdef MBIST_DIAG_EN
        efa = v.exp_faddr;
        efe = v.exp_felem;
`else
        efa = 0;
        efe = 0;
`endif
        @(negedge MCK);
        push_march();
        men = 1'b1;
        @(negedge MCK);
        n = 0;
        while (mrd !== 1'b1 && n < BUDGET) begin
            if (n == 60) chk("mgo_mid", 64'(mgo), 64'(v.exp_mgo_mid));
            @(negedge MCK);
            n++;
        end
        chk("done_cycle", 64'(n), 64'(NOPS + 2));
        chk("mgo_final", 64'(mgo), 64'(v.exp_mgo));
        chk("ops_left", 64'(sb_q.size()), 64'd0);
        chk("fail_addr", 64'(fail_addr), 64'(efa));
        chk("fail_elem", 64'(fail_elem), 64'(efe));
        bad = 0;
        repeat (100) begin
            @(negedge MCK);
            if (mrd !== 1'b1 || mgo !== v.exp_mgo) bad++;
        end
        chk("done_hold_stable", 64'(bad), 64'd0);
        men = 1'b0;
        @(negedge MCK);
        chk("mrd_clear", 64'(mrd), 64'd0);
        chk("mgo_kept", 64'(mgo), 64'(v.exp_mgo));
        chk("idle_cen", 64'(mem_cen), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_outs"}, 64'({mgo, mrd, mem_cen, mem_wen, mem_oen}), 64'(5'b00111));
        chk({tag, "_a_d"}, 64'({mem_a, mem_d}), 64'd0);
        chk({tag, "_fail"}, 64'({fail_addr, fail_elem}), 64'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 0, 0, 1'b1, 1'b1, 0, 0};
        vecs[1] = '{1, 3, 5, 1'b0, 1'b0, 3, 1};
        vecs[2] = '{2, 9, 0, 1'b1, 1'b0, 9, 2};
        vecs[3] = '{0, 0, 0, 1'b1, 1'b1, 0, 0};

        RSTN  = 1'b0;
        men   = 1'b0;
        men_b = 1'b0;
        repeat (3) @(negedge MCK);
        chk_reset_vals("reset");
        RSTN = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // men dropped inside element 2, then restart from element 0
        fault_mode = 0;
        @(negedge MCK);
        push_march();
        men = 1'b1;
        repeat (61) @(negedge MCK);
        men = 1'b0;
        @(negedge MCK);
        chk("drop_cen", 64'(mem_cen), 64'd1);
        chk("drop_mrd", 64'(mrd), 64'd0);
        chk("drop_mgo", 64'(mgo), 64'd1);
        push_march();
        men = 1'b1;
        @(negedge MCK);
        @(negedge MCK);
        chk("restart_first_op", 64'({mem_cen, mem_wen, mem_a}), 64'd0);
        n = 1;
        while (mrd !== 1'b1 && n < BUDGET) begin
            @(negedge MCK);
            n++;
        end
        chk("restart_done_cycle", 64'(n), 64'(NOPS + 2));
        chk("restart_mgo", 64'(mgo), 64'd1);
        men = 1'b0;
        @(negedge MCK);

        // asynchronous reset in the middle of a run
        push_march();
        men = 1'b1;
        repeat (50) @(negedge MCK);
        RSTN = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        sb_q.delete();
        men = 1'b0;
        @(negedge MCK);
        RSTN = 1'b1;
        run_vec(vecs[0]);

        // full-size smoke run
        @(negedge MCK);
        men_b = 1'b1;
        @(negedge MCK);
        n = 0;
        while (mrd_b !== 1'b1 && n < 50000) begin
            @(negedge MCK);
            n++;
        end
        chk("big_done_cycle", 64'(n), 64'(10 * (1 << BAW) + 2));
        chk("big_mgo", 64'(mgo_b), 64'd1);
        men_b = 1'b0;
        @(negedge MCK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
